// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of a single-cycle, word-write data memory. It takes one
//   RV32I load/store at a time and drives the memory pins from registered
//   state only. Sub-word stores are done as a read-modify-write of the word.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_write, req_funct3     1=store / 0=load, RV32I width+sign encoding
//   req_addr, req_wdata       byte address, store data
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      load result / error flag, held until next resp
//   mem_address               word-aligned memory address
//   mem_read, mem_write       memory strobes, never high together
//   mem_wdata, mem_rdata      memory write data / combinational read data
//
// Build option
//   LSU_BOUNDS_CHECK_EN       when defined, accesses outside
//                             [BASE, BASE+SIZE-1] complete with resp_err.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// LOAD  | mem_read asserted, result captured at end of cycle
// ST_RD | mem_read of the word to be merged (SB/SH)
// ST_WR | mem_write of the merged / full word
// RESP  | resp_valid pulse
module load_store_unit #(
  parameter int              AW   = 32,
  parameter int              DW   = 32,
  parameter logic [AW-1:0]   BASE = 'h1000,
  parameter int              SIZE = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_t;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [AW:0] LAST = {1'b0, BASE} + (AW+1)'(SIZE) - 1'b1;

  state_t        state_q, state_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          illegal, misaligned, range_err, req_err;
  logic [AW:0]   width_m1;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [DW-1:0] load_val, merged;

  // request error decode, evaluated only in IDLE
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_write;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    width_m1 = (req_funct3[1:0] == 2'b00) ? (AW+1)'(0) :
               (req_funct3[1:0] == 2'b01) ? (AW+1)'(1) : (AW+1)'(3);
    range_err = BOUNDS_EN &&
                ((req_addr < BASE) || (({1'b0, req_addr} + width_m1) > LAST));
    req_err = illegal || misaligned || range_err;
  end

  // lane selection and extension for loads; lane merge for sub-word stores
  always_comb begin
    case (addr_lo_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_val = {24'h0, lane_b};
      3'b101:  load_val = {16'h0, lane_h};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_lo_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_lo_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_lo_d     = addr_lo_q;
    funct3_d      = funct3_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_err_d    = resp_err_q;
    mem_address_d = mem_address_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_wdata_d   = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d = req_addr[1:0];
          funct3_d  = req_funct3;
          wdata_d   = req_wdata;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            mem_address_d = {req_addr[AW-1:2], 2'b00};
            if (!req_write) begin
              state_d    = LOAD;
              mem_read_d = 1'b1;
            end else if (req_funct3[1:0] == 2'b10) begin
              // full word store needs no read
              state_d     = ST_WR;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d    = ST_RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_val;
      end
      ST_RD: begin
        state_d     = ST_WR;
        mem_write_d = 1'b1;
        mem_wdata_d = merged;
      end
      ST_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_lo_q     <= '0;
      funct3_q      <= '0;
      wdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      funct3_q      <= funct3_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_err_q    <= resp_err_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a word-write memory sits on the mem_* pins,
// while a byte-array reference model predicts results, latency and the
// store word that should reach memory.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h1000;
  localparam int          SIZE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dmem [0:SIZE/4-1];
  logic [7:0]  ref_mem [0:SIZE-1];

  always #5 clk = ~clk;

  load_store_unit #(.AW(32), .DW(32), .BASE(BASE), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic bit in_mem(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SIZE);
  endfunction

  always_comb begin
    mem_rdata = 32'h0;
    if (in_mem(mem_address)) mem_rdata = dmem[(mem_address - BASE) >> 2];
  end

  always @(posedge clk)
    if (mem_write && in_mem(mem_address)) dmem[(mem_address - BASE) >> 2] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return in_mem(a) ? ref_mem[a - BASE] : 8'h00;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
    int          width, lat_exp, resp_n;
    bit          legal, err_exp, rd_exp, wr_exp, seen_rd, seen_wr, both;
    int          n_wr;
    logic [31:0] rdata_exp, word_exp, rd_addr, wr_addr, wr_data, got_rdata;
    logic        got_err;
    logic [31:0] wa;

    legal   = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
              (!wr && (f3 == 3'd4 || f3 == 3'd5));
    width   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err_exp = !legal || ((addr % width) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr < BASE || addr + width - 1 > BASE + SIZE - 1) err_exp = 1'b1;
`endif
    wa        = addr & ~32'd3;
    rdata_exp = 32'h0;
    word_exp  = 32'h0;
    rd_exp    = 1'b0;
    wr_exp    = 1'b0;
    if (err_exp) begin
      lat_exp = 1;
    end else if (!wr) begin
      lat_exp = 2;
      rd_exp  = 1'b1;
      for (int i = 0; i < width; i++) rdata_exp |= 32'(ref_byte(addr + i)) << (8 * i);
      if (!f3[2] && width < 4 && rdata_exp[8*width-1])
        rdata_exp |= ~((32'd1 << (8 * width)) - 1);
    end else begin
      lat_exp = (width == 4) ? 2 : 3;
      rd_exp  = (width != 4);
      wr_exp  = 1'b1;
      for (int i = 0; i < width; i++)
        if (in_mem(addr + i)) ref_mem[addr + i - BASE] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) word_exp |= 32'(ref_byte(wa + i)) << (8 * i);
    end

    wait_ready(tag);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = $urandom_range(0, 1);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    seen_rd = 0; seen_wr = 0; both = 0; n_wr = 0; resp_n = 0;
    rd_addr = 0; wr_addr = 0; wr_data = 0; got_rdata = 0; got_err = 0;
    for (int n = 1; n <= 8 && resp_n == 0; n++) begin
      @(negedge clk);
      if (mem_read && mem_write) both = 1;
      if (mem_read) begin seen_rd = 1; rd_addr = mem_address; end
      if (mem_write) begin seen_wr = 1; n_wr++; wr_addr = mem_address; wr_data = mem_wdata; end
      if (resp_valid) begin
        resp_n    = n;
        got_rdata = resp_rdata;
        got_err   = resp_err;
      end
    end
    check({tag, " latency"}, resp_n, lat_exp);
    check({tag, " err"}, {31'b0, got_err}, {31'b0, err_exp});
    check({tag, " rdata"}, got_rdata, rdata_exp);
    check({tag, " mem_read"}, {31'b0, seen_rd}, {31'b0, rd_exp});
    check({tag, " mem_write count"}, n_wr, wr_exp ? 1 : 0);
    check({tag, " rd/wr overlap"}, {31'b0, both}, 32'd0);
    if (rd_exp) check({tag, " read addr"}, rd_addr, wa);
    if (wr_exp) begin
      check({tag, " write addr"}, wr_addr, wa);
      check({tag, " write data"}, wr_data, word_exp);
    end
  endtask

  initial begin
    logic [31:0] w;
    bit          wr_seen;

    for (int i = 0; i < SIZE / 4; i++) begin
      w = $urandom;
      if (i == 1) w = 32'h8899AABB;
      dmem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", {31'b0, req_ready}, 32'd1);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err", {31'b0, resp_err}, 32'd0);
    check("rst mem_address", mem_address, 32'd0);
    check("rst mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    run_req(1'b0, 3'b000, 32'h1005, 32'h0, "LB 1005");
    run_req(1'b0, 3'b100, 32'h1005, 32'h0, "LBU 1005");
    run_req(1'b0, 3'b001, 32'h1006, 32'h0, "LH 1006");
    run_req(1'b0, 3'b101, 32'h1006, 32'h0, "LHU 1006");
    run_req(1'b0, 3'b010, 32'h1004, 32'h0, "LW 1004");
    run_req(1'b1, 3'b000, 32'h1005, 32'h12345677, "SB 1005");
    run_req(1'b0, 3'b010, 32'h1004, 32'h0, "LW after SB");
    run_req(1'b1, 3'b001, 32'h1003, 32'hDEADBEEF, "SH 1003 misaligned");
    run_req(1'b0, 3'b010, 32'h1002, 32'h0, "LW 1002 misaligned");
    run_req(1'b1, 3'b100, 32'h1008, 32'h0, "SBU illegal");
    run_req(1'b0, 3'b011, 32'h1008, 32'h0, "funct3 011 illegal");
    repeat (3) @(negedge clk);
    check("idle mem_address hold", mem_address, 32'h1004);
    run_req(1'b0, 3'b010, 32'h1400, 32'h0, "LW 1400 bounds");

    // SB aborted by reset while the read half is in progress
    wait_ready("abort");
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h1005; req_wdata = 32'h000000CC;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort st_rd mem_read", {31'b0, mem_read}, 32'd1);
    wr_seen = mem_write;
    rst = 1'b1;
    @(negedge clk);
    check("abort req_ready", {31'b0, req_ready}, 32'd1);
    check("abort resp", {29'b0, resp_valid, resp_err, |resp_rdata}, 32'd0);
    check("abort mem_address", mem_address, 32'd0);
    check("abort mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (mem_write) wr_seen = 1'b1;
      @(negedge clk);
    end
    check("abort no mem_write", {31'b0, wr_seen}, 32'd0);
    run_req(1'b0, 3'b010, 32'h1004, 32'h0, "LW after abort");

    for (int k = 0; k < 200; k++) begin
      logic [2:0]  f3;
      logic        wr;
      logic [31:0] a;
      f3 = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3 = (f3[2] && f3[1]) ? 3'b010 : f3;
      wr = $urandom_range(0, 1);
      a  = BASE + $urandom_range(0, SIZE - 4);
      if ($urandom_range(0, 2) != 0) a = a & ~((f3[1:0] == 2'd2) ? 32'd3 : (f3[1:0] == 2'd1) ? 32'd1 : 32'd0);
      run_req(wr, f3, a, $urandom, $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
